// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - button/digit bundle between calculator entry logic and calc_sequencer
//
// Purpose: groups the operator button, the digit-entry value and the result/status
// outputs of calc_sequencer into one interface.
// Signals:
//   next_op     raw step pushbutton level, active-low
//   digits_in   four BCD digits from the entry registers ([3:0] units)
//   result_bcd  BCD value for the digit registers
//   digit_load  one-cycle load strobe for the digit registers
//   step        entry phase: 0 = A, 1 = B, 2 = op select
//   busy        high while a calculation is in flight
//   error       sticky flag, last result invalid
// Modports: slave = calc_sequencer side, master = entry/display side.
interface calc_sequencer_if;
  logic        next_op;
  logic [15:0] digits_in;
  logic [15:0] result_bcd;
  logic        digit_load;
  logic [1:0]  step;
  logic        busy;
  logic        error;

  modport slave (
    input  next_op, digits_in,
    output result_bcd, digit_load, step, busy, error
  );

  modport master (
    output next_op, digits_in,
    input  result_bcd, digit_load, step, busy, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - single-clock sequencer for the four-digit calculator datapath
//
// Purpose: synchronizes the step button, captures operand A, operand B and the op
// code from the digit-entry registers, evaluates the operation, converts the binary
// result to BCD with a shift-add-3 sequence and issues one digit_load strobe.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    calc_sequencer_if.slave (next_op, digits_in in; result_bcd, digit_load,
//          step, busy, error out)
// Parameters:
//   CONV_STEPS  double-dabble iterations, equal to the 14-bit result width
// Build option:
//   CALC_DIV_EN  when defined, op 3 runs a 14-cycle restoring divider (A/B);
//                when undefined, op 3 is reported invalid.
module calc_sequencer #(
  parameter int CONV_STEPS = 14
) (
  input  logic            clk,
  input  logic            reset,
  calc_sequencer_if.slave bus
);

  localparam int            CW        = $clog2(CONV_STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(CONV_STEPS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_SELECT  = 3'd3,
    S_EXEC    = 3'd4,
`ifdef CALC_DIV_EN
    S_DIV     = 3'd5,
`endif
    S_CONV    = 3'd6,
    S_LOAD    = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    w_step;
  logic          w_busy;

  logic          r_sync1, r_sync2, r_sync3, r_press;
  logic [13:0]   r_a, r_b, r_bin;
  logic [3:0]    r_op;
  logic [14:0]   r_bcd;
  logic [CW-1:0] r_cnt;
  logic          r_bad;
  logic [15:0]   r_result;
  logic          r_error;
  logic          r_digit_load;

  // Button: two synchronizer flops, one history flop, registered falling-edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= bus.next_op;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_press <= r_sync3 & ~r_sync2;
    end
  end

  // Entry value from the four BCD digits, each clamped to 9.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [13:0] w_entry;
  assign w_entry = 14'(clamp9(bus.digits_in[3:0]))
                 + 14'(clamp9(bus.digits_in[7:4]))   * 14'd10
                 + 14'(clamp9(bus.digits_in[11:8]))  * 14'd100
                 + 14'(clamp9(bus.digits_in[15:12])) * 14'd1000;

  // Arithmetic evaluated in the EXEC cycle.
  logic [14:0] w_sum, w_diff;
  logic [27:0] w_prod;
  logic [13:0] w_exec_bin;
  logic        w_exec_bad;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_prod = 28'(r_a) * 28'(r_b);

  always_comb begin
    w_exec_bin = '0;
    w_exec_bad = 1'b1;
    case (r_op)
      4'd0: begin
        w_exec_bin = w_sum[13:0];
        w_exec_bad = (w_sum > 15'd9999);
      end
      4'd1: begin
        // Borrow out of the 15-bit difference means A < B.
        w_exec_bin = w_diff[13:0];
        w_exec_bad = w_diff[14];
      end
      4'd2: begin
        w_exec_bin = w_prod[13:0];
        w_exec_bad = (w_prod > 28'd9999);
      end
`ifdef CALC_DIV_EN
      4'd3: begin
        // Dividend goes into r_bin; the divider shifts the quotient in behind it.
        w_exec_bin = r_a;
        w_exec_bad = (r_b == 14'd0);
      end
`endif
      default: begin
        w_exec_bin = '0;
        w_exec_bad = 1'b1;
      end
    endcase
  end

`ifdef CALC_DIV_EN
  // Restoring divider: one quotient bit per cycle, MSB of the dividend first.
  logic [14:0] r_rem;
  logic [15:0] w_rem_shift;
  logic [14:0] w_rem_sub;
  logic        w_rem_ge;

  assign w_rem_shift = {r_rem, r_bin[13]};
  assign w_rem_ge    = (w_rem_shift >= {2'b00, r_b});
  assign w_rem_sub   = w_rem_shift[14:0] - {1'b0, r_b};
`endif

  // Double-dabble step. Only the three low digits need the add-3 correction: the
  // result is at most 9999, so the thousands digit is at most 4 before its last shift.
  function automatic logic [14:0] dd_adjust(input logic [14:0] v);
    logic [14:0] o;
    o = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] >= 4'd5) o[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return o;
  endfunction

  logic [14:0] w_dd_adj;
  logic [15:0] w_dd_next;
  assign w_dd_adj  = dd_adjust(r_bcd);
  assign w_dd_next = {w_dd_adj, r_bin[13]};

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  // FSM next state and Moore outputs. Presses are consumed only in the entry states.
  always_comb begin
    w_next = r_state;
    w_step = 2'd0;
    w_busy = 1'b0;
    case (r_state)
      S_CLEAR:   w_next = S_ENTER_A;
      S_ENTER_A: if (r_press) w_next = S_ENTER_B;
      S_ENTER_B: begin
        w_step = 2'd1;
        if (r_press) w_next = S_SELECT;
      end
      S_SELECT: begin
        w_step = 2'd2;
        if (r_press) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_step = 2'd2;
        w_busy = 1'b1;
`ifdef CALC_DIV_EN
        w_next = (r_op == 4'd3) ? S_DIV : S_CONV;
`else
        w_next = S_CONV;
`endif
      end
`ifdef CALC_DIV_EN
      S_DIV: begin
        w_step = 2'd2;
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_CONV;
      end
`endif
      S_CONV: begin
        w_step = 2'd2;
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_step = 2'd2;
        w_busy = 1'b1;
        w_next = S_ENTER_A;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // Datapath. Invalid results still walk through DIV/CONV so latency never depends
  // on the outcome; only the value written at the end changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_bad        <= 1'b0;
      r_result     <= '0;
      r_error      <= 1'b0;
      r_digit_load <= 1'b0;
`ifdef CALC_DIV_EN
      r_rem        <= '0;
`endif
    end else begin
      // Registered strobe lines up with the CLEAR exit and with the LOAD state.
      r_digit_load <= (r_state == S_CLEAR) || (w_next == S_LOAD);
      case (r_state)
        S_CLEAR: r_result <= '0;
        S_ENTER_A: begin
          if (r_press) begin
            r_a     <= w_entry;
            r_error <= 1'b0;
          end
        end
        S_ENTER_B: if (r_press) r_b <= w_entry;
        S_SELECT:  if (r_press) r_op <= bus.digits_in[3:0];
        S_EXEC: begin
          r_bin <= w_exec_bin;
          r_bad <= w_exec_bad;
          r_bcd <= '0;
          r_cnt <= LAST_STEP;
`ifdef CALC_DIV_EN
          r_rem <= '0;
`endif
        end
`ifdef CALC_DIV_EN
        S_DIV: begin
          r_rem <= w_rem_ge ? w_rem_sub : w_rem_shift[14:0];
          r_bin <= {r_bin[12:0], w_rem_ge};
          r_cnt <= (r_cnt == '0) ? LAST_STEP : r_cnt - ONE;
        end
`endif
        S_CONV: begin
          r_bcd <= w_dd_next[14:0];
          r_bin <= {r_bin[12:0], 1'b0};
          if (r_cnt == '0) begin
            r_result <= r_bad ? 16'h7777 : w_dd_next;
            if (r_bad) r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_bcd = r_result;
  assign bus.digit_load = r_digit_load;
  assign bus.step       = w_step;
  assign bus.busy       = w_busy;
  assign bus.error      = r_error;

endmodule
